l2_req_bridge: RTL

//  Downstream neighbour of the coherence controller's L2 port. Accepts one word

---
 rtl/l2_req_bridge.sv | 116 +++++++++++
 1 files changed

// File: rtl/l2_req_bridge.sv
// Bridges one L2 word request at a time onto a busy-handshake memory bus.
// Flags misaligned requests, REN/WEN conflicts and bus timeouts as L2_ERROR.
module l2_req_bridge #(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              l2REN,
  input  logic              l2WEN,
  input  logic [ADDR_W-1:0] l2addr,
  input  logic [31:0]       l2store,
  output logic [1:0]        l2state,
  output logic [31:0]       l2load,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_busy,
  output logic [1:0]        err_code
);

  // state | meaning
  // IDLE  | FREE, waiting for a request
  // MEM   | BUSY, strobe held until mem_busy drops or timeout
  // RESP  | ACCESS for one cycle
  // ERR   | ERROR for one cycle
  typedef enum logic [1:0] {IDLE, MEM, RESP, ERR} state_t;

  localparam logic [1:0] L2_FREE   = 2'd0;
  localparam logic [1:0] L2_BUSY   = 2'd1;
  localparam logic [1:0] L2_ACCESS = 2'd2;
  localparam logic [1:0] L2_ERROR  = 2'd3;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ALIGN    = 2'd1;
  localparam logic [1:0] ERR_CONFLICT = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      l2state   <= L2_FREE;
      l2load    <= '0;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err_code  <= ERR_NONE;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (l2REN || l2WEN) begin
            mem_addr  <= l2addr;
            mem_wdata <= l2store;
            err_code  <= ERR_NONE;
            if (l2REN && l2WEN) begin
              state    <= ERR;
              l2state  <= L2_ERROR;
              err_code <= ERR_CONFLICT;
            end else if (l2addr[1:0] != 2'b00) begin
              state    <= ERR;
              l2state  <= L2_ERROR;
              err_code <= ERR_ALIGN;
            end else begin
              state   <= MEM;
              l2state <= L2_BUSY;
              mem_ren <= l2REN;
              mem_wen <= l2WEN;
            end
          end
        end
        MEM: begin
          if (!mem_busy) begin
            if (mem_ren) l2load <= mem_rdata;
            mem_ren <= 1'b0;
            mem_wen <= 1'b0;
            tmo_cnt <= '0;
            state   <= RESP;
            l2state <= L2_ACCESS;
          end else if (TIMEOUT > 0 && tmo_cnt == CNT_LAST) begin
            // Busy through the last allowed cycle: abandon the bus access.
            mem_ren  <= 1'b0;
            mem_wen  <= 1'b0;
            tmo_cnt  <= '0;
            err_code <= ERR_TIMEOUT;
            state    <= ERR;
            l2state  <= L2_ERROR;
          end else if (TIMEOUT > 0) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP, ERR: begin
          state   <= IDLE;
          l2state <= L2_FREE;
        end
        default: begin
          state   <= IDLE;
          l2state <= L2_FREE;
          mem_ren <= 1'b0;
          mem_wen <= 1'b0;
          tmo_cnt <= '0;
        end
      endcase
    end
  end

endmodule
